// File: rtl/data_ram_pkg.sv
// Shared constants, FSM state type and access-size decode for data_ram.
// Halfword accesses are decoded only when DATA_RAM_HALFWORD_EN is defined.
package data_ram_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Access size in bytes; 0 marks an unsupported funct3.
  function automatic logic [2:0] access_size(input logic write, input logic [2:0] funct3);
    logic [2:0] size;
    size = 3'd0;
    if (write) begin
      case (funct3)
        SB: size = 3'd1;
`ifdef DATA_RAM_HALFWORD_EN
        SH: size = 3'd2;
`else
        SH: size = 3'd0;
`endif
        SW: size = 3'd4;
        default: size = 3'd0;
      endcase
    end else begin
      case (funct3)
        LB, LBU: size = 3'd1;
`ifdef DATA_RAM_HALFWORD_EN
        LH, LHU: size = 3'd2;
`else
        LH, LHU: size = 3'd0;
`endif
        LW: size = 3'd4;
        default: size = 3'd0;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/data_ram_align.sv
// Combinational lane steering, byte enables, fault decode and load extension.
// Accesses never straddle a word: anything that would is rejected as misaligned.
module data_ram_align
  import data_ram_pkg::*;
#(
  parameter int MEM_BYTES = 128
) (
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        fault,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        misalign;
  logic [31:0] shifted;

  always_comb begin
    size     = access_size(write, funct3);
    // One extra bit keeps addresses near 2^32 from wrapping back into range.
    end_addr = {1'b0, addr} + {30'd0, size};
    misalign = ((size == 3'd2) && addr[0]) || ((size == 3'd4) && (addr[1:0] != 2'b00));
    fault    = (size == 3'd0) || misalign || (end_addr > 33'(MEM_BYTES));

    be = 4'b0000;
    if (!fault) begin
      case (size)
        3'd1:    be = 4'b0001 << addr[1:0];
        3'd2:    be = 4'b0011 << {addr[1], 1'b0};
        3'd4:    be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end

    wword   = wdata << {addr[1:0], 3'b000};
    shifted = rword >> {addr[1:0], 3'b000};

    rdata = 32'd0;
    if (!fault && !write) begin
      case (funct3)
        LB:      rdata = {{24{shifted[7]}}, shifted[7:0]};
        LH:      rdata = {{16{shifted[15]}}, shifted[15:0]};
        LW:      rdata = shifted;
        LBU:     rdata = {24'd0, shifted[7:0]};
        LHU:     rdata = {16'd0, shifted[15:0]};
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: rtl/data_ram.sv
// Single-outstanding RV32I load/store RAM with optional stall cycles.
// Define DATA_RAM_HALFWORD_EN to enable lh/lhu/sh.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int MEM_BYTES   = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int NW   = MEM_BYTES / 4;
  localparam int WIDX = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;

  // Contents are not reset; they start at zero and survive rst.
  logic [NW-1:0][31:0] mem_q = '0;
  logic [NW-1:0][31:0] mem_d;

  logic        use_live;
  logic        acc_write;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [29:0] wsel;
  logic [31:0] rword;
  logic        fault;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] rdata;
  logic        do_acc;

  // With no stall the access happens on the accept edge, so use the live request.
  always_comb begin
    use_live  = (state_q == ST_IDLE);
    acc_write = use_live ? req_write  : wr_q;
    acc_f3    = use_live ? req_funct3 : f3_q;
    acc_addr  = use_live ? req_addr   : addr_q;
    acc_wdata = use_live ? req_wdata  : wdata_q;
    wsel      = acc_addr[31:2];
    rword     = (wsel < 30'(NW)) ? mem_q[wsel[WIDX-1:0]] : 32'd0;
  end

  data_ram_align #(.MEM_BYTES(MEM_BYTES)) u_align (
    .write  (acc_write),
    .funct3 (acc_f3),
    .addr   (acc_addr),
    .wdata  (acc_wdata),
    .rword  (rword),
    .fault  (fault),
    .be     (be),
    .wword  (wword),
    .rdata  (rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    do_acc  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            do_acc  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_acc  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = do_acc;
    resp_fault_d = do_acc & fault;
    resp_rdata_d = do_acc ? rdata : 32'd0;

    mem_d = mem_q;
    if (do_acc && acc_write && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_d[wsel[WIDX-1:0]][8*b +: 8] = wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // A store in flight when rst arrives must never land.
  always_ff @(posedge clk) begin
    if (!rst) mem_q <= mem_d;
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_data_ram.sv
// Randomized bench for data_ram against a byte-array reference model, plus directed literal checks.
module tb_data_ram;

  localparam int MEM = 128;
  localparam int W   = 2;
`ifdef DATA_RAM_HALFWORD_EN
  localparam bit HW = 1'b1;
`else
  localparam bit HW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  data_ram #(.MEM_BYTES(MEM), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  byte unsigned mem [MEM] = '{default: 8'd0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int sz(input bit w, input logic [2:0] f3);
    if (f3 == 3'd0 || (!w && f3 == 3'd4)) return 1;
    if (f3 == 3'd2) return 4;
    if (HW && (f3 == 3'd1 || (!w && f3 == 3'd5))) return 2;
    return 0;
  endfunction

  // Reference: byte-addressed memory, little-endian, faults from plain arithmetic.
  task automatic model_exec(input bit w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output bit flt, output logic [31:0] rd);
    int s;
    longint ea;
    longint unsigned v;
    s  = sz(w, f3);
    ea = longint'(a);
    flt = 1'b0;
    if (s == 0) flt = 1'b1;
    else if ((ea % s) != 0) flt = 1'b1;
    else if (ea + s > MEM) flt = 1'b1;
    rd = 32'd0;
    if (!flt) begin
      if (w) begin
        for (int i = 0; i < s; i++) mem[int'(ea) + i] = 8'((wd >> (8 * i)) & 32'hFF);
      end else begin
        v = 0;
        for (int i = 0; i < s; i++) v = v + (longint'(mem[int'(ea) + i]) << (8 * i));
        if (f3 == 3'd0 && v >= 128) v = v + 64'hFFFFFF00;
        if (f3 == 3'd1 && v >= 32768) v = v + 64'hFFFF0000;
        rd = v[31:0];
      end
    end
  endtask

  // Per-cycle comparison against the model's view of the handshake.
  int          cyc = 0;
  int          due = 0;
  bit          pend = 1'b0;
  bit          p_w;
  logic [2:0]  p_f3;
  logic [31:0] p_a, p_wd;
  bit          ev, er, ef;
  logic [31:0] erd;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 1'b0;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_fault", 32'(resp_fault), 32'd0);
    end else begin
      ev = pend && (cyc == due);
      er = !pend;
      chk("ready", 32'(req_ready), 32'(er));
      chk("valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
        model_exec(p_w, p_f3, p_a, p_wd, ef, erd);
        chk("rdata", resp_rdata, erd);
        chk("fault", 32'(resp_fault), 32'(ef));
        pend = 1'b0;
      end else begin
        chk("idle_rdata", resp_rdata, 32'd0);
      end
      if (er && req_valid) begin
        pend = 1'b1;
        due  = cyc + 1 + W;
        p_w  = req_write;
        p_f3 = req_funct3;
        p_a  = req_addr;
        p_wd = req_wdata;
      end
    end
  end

  task automatic drive(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL %s_accept_timeout actual=busy expected=ready", nm);
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns likewise.
  task automatic txn(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input bit lit, input logic [31:0] xrd, input bit xf, input string nm);
    int n;
    drive(w, f3, a, wd);
    wait_ready(nm);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 50);
    chk({nm, "_lat"}, 32'(n), 32'(W + 1));
    if (lit) begin
      chk({nm, "_rdata"}, resp_rdata, xrd);
      chk({nm, "_fault"}, 32'(resp_fault), 32'(xf));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int pulses, readies, r;
    bit w;
    logic [2:0] f3;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    txn(1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, "sw_10");
    txn(0, 3'b010, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, "lw_10");
    txn(1, 3'b000, 32'h13, 32'h80, 1, 32'h0, 0, "sb_13");
    txn(0, 3'b000, 32'h13, 32'h0, 1, 32'hFFFFFF80, 0, "lb_13");
    txn(0, 3'b100, 32'h13, 32'h0, 1, 32'h00000080, 0, "lbu_13");
    txn(0, 3'b010, 32'h10, 32'h0, 1, 32'h80ADBEEF, 0, "lw_10_after_sb");
    txn(0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1, "lw_12_misalign");
    txn(1, 3'b010, 32'h7E, 32'hFFFFFFFF, 1, 32'h0, 1, "sw_7e");
    txn(0, 3'b010, 32'h7C, 32'h0, 1, 32'h0, 0, "lw_7c");
    txn(1, 3'b001, 32'h20, 32'h8001, 1, 32'h0, !HW, "sh_20");
    txn(0, 3'b101, 32'h20, 32'h0, 1, HW ? 32'h00008001 : 32'h0, !HW, "lhu_20");
    txn(0, 3'b001, 32'h20, 32'h0, 1, HW ? 32'hFFFF8001 : 32'h0, !HW, "lh_20");
    txn(0, 3'b010, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 1, "lw_ffffffff");
    txn(0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1, "load_f3_011");
    txn(1, 3'b110, 32'h0, 32'h1, 1, 32'h0, 1, "store_f3_110");

    // Reset during the stall of a store.
    drive(1, 3'b010, 32'h30, 32'h12345678);
    wait_ready("sw_30");
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    txn(0, 3'b010, 32'h30, 32'h0, 1, 32'h0, 0, "lw_30_after_rst");

    // Held req_valid: one accept per W+2 cycles.
    drive(0, 3'b010, 32'h10, 32'h0);
    wait_ready("held");
    pulses = 0;
    readies = 0;
    for (int i = 0; i < 4 * (W + 2); i++) begin
      if (i > 0) @(negedge clk);
      if (resp_valid) pulses++;
      if (req_ready) readies++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd4);
    chk("held_readies", 32'(readies), 32'd4);
    wait_ready("held_drain");
    @(posedge clk);
    #1;

    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 9));
      if (r < 7) a = 32'($urandom_range(0, MEM + 3));
      else if (r == 7) a = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, MEM / 4 - 1)) * 32'd4;
      txn(w, f3, a, $urandom, 0, 32'h0, 0, "rand");
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, meaning storage size in bytes; must be a multiple of 4 and at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, meaning extra stall cycles between accept and access; range 0-15.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, meaning a request is presented.
REQ-006 SHALL have port req_ready, output, 1, meaning the block can accept a request.
REQ-007 SHALL have port req_write, input, 1, meaning 1=store, 0=load.
REQ-008 SHALL have port req_funct3, input, 3, meaning RV32I load/store funct3.
REQ-009 SHALL have port req_addr, input, 32, meaning byte address.
REQ-010 SHALL have port req_wdata, input, 32, meaning store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, meaning response present, one-cycle pulse.
REQ-012 SHALL have port resp_rdata, output, 32, meaning load result, extended.
REQ-013 SHALL have port resp_fault, output, 1, meaning access rejected; valid with resp_valid.

Function
REQ-014 SHALL run FSM IDLE -> WAIT -> RESP -> IDLE; WAIT is skipped when WAIT_CYCLES=0.
REQ-015 SHALL assert req_ready only in IDLE; accept = req_valid & req_ready at a rising edge; all req_* fields are captured at accept.
REQ-016 SHALL hold WAIT for exactly WAIT_CYCLES cycles using a down-counter loaded at accept.
REQ-017 SHALL perform the memory access on the edge entering RESP: at the accept edge when WAIT_CYCLES=0, otherwise at the last WAIT edge.
REQ-018 SHALL hold resp_valid high for exactly one cycle (RESP), then return to IDLE with req_ready=1; at most one request is outstanding.
REQ-019 SHALL store bytes little-endian: sb writes 1 byte at addr, sh 2 bytes, sw 4 bytes.
REQ-020 SHALL return loads as follows: lb/lh sign-extended; lbu/lhu zero-extended; lw raw.
REQ-021 SHALL flag a fault when sh/lh/lhu has addr[0]!=0 or sw/lw has addr[1:0]!=0.
REQ-022 SHALL flag a fault when addr+size > MEM_BYTES, computed without 32-bit wrap (e.g. 0xFFFF_FFFF faults).
REQ-023 SHALL flag a fault for an unsupported funct3.
REQ-024 SHALL, on fault, leave memory unmodified and drive resp_rdata=0 and resp_fault=1; otherwise resp_fault=0.
REQ-025 SHALL drive resp_rdata=0 for stores and whenever resp_valid=0.
REQ-026 SHALL allow sb at any in-range address; no word alignment is required.
REQ-027 SHALL ignore req_valid while not in IDLE; the request is neither captured nor queued.

Reset
REQ-028 SHALL on rst: force state to IDLE, clear the counter, and set req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0.
REQ-029 SHALL discard a store pending in WAIT when rst is asserted mid-operation; memory is not written.
REQ-030 SHALL leave memory contents unchanged by rst; contents initialise to all-zero at simulation start.

Configuration
REQ-031 SHALL, with DATA_RAM_HALFWORD_EN defined, support lh (001), lhu (101) and sh (001).
REQ-032 SHALL, without DATA_RAM_HALFWORD_EN, treat funct3 001 and 101 as unsupported (fault, no write); all other behaviour is identical.

Structure
REQ-033 SHALL place the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), the FSM state enum and the size-decode function in package data_ram_pkg.
REQ-034 SHALL isolate lane steering, byte-enable generation, fault decode and load extension in combinational sub-module data_ram_align.

Verification
REQ-035 SHALL verify: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> rdata 0xDEADBEEF, fault 0; with WAIT_CYCLES=2, resp_valid occurs 3 cycles after accept.
REQ-036 SHALL verify: sb 0x13 data 0x80, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
REQ-037 SHALL verify: lw 0x12 -> fault 1, rdata 0; sw 0x7E -> fault 1 and memory unchanged; lw 0x7C (MEM_BYTES=128) -> fault 0.
REQ-038 SHALL verify: sh 0x20 data 0x8001, then lhu 0x20 -> 0x00008001, lh 0x20 -> 0xFFFF8001 with the macro defined; without the macro both give fault 1.
REQ-039 SHALL verify: rst asserted during WAIT of sw 0x30 data 0x12345678 -> req_ready=1 and resp_valid=0 next cycle, and lw 0x30 afterwards -> 0x00000000.
REQ-040 SHALL verify: req_valid held high continuously -> one accept per WAIT_CYCLES+2 cycles and req_ready=0 throughout WAIT and RESP.
